// File: rtl/regfile_wb_scheduler_if.sv
// Issue, writeback-request and register-file write-port bundle for the writeback scheduler.
// The master side is the issue stage plus writeback sources; the slave side is the scheduler.
interface regfile_wb_scheduler_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
);
    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic            issue_wr;
    logic [AW-1:0]   issue_rd;
    logic            issue_stall;

    logic            wb0_valid;
    logic [AW-1:0]   wb0_adr;
    logic [XLEN-1:0] wb0_data;
    logic            wb0_ready;

    logic            wb1_valid;
    logic [AW-1:0]   wb1_adr;
    logic [XLEN-1:0] wb1_data;
    logic            wb1_ready;

    logic            reg_write;
    logic [AW-1:0]   write_adr;
    logic [XLEN-1:0] write_data;
    logic [NREG-1:0] busy;
    logic            err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_wr, issue_rd,
        output wb0_valid, wb0_adr, wb0_data,
        output wb1_valid, wb1_adr, wb1_data,
        input  issue_stall, wb0_ready, wb1_ready,
        input  reg_write, write_adr, write_data, busy, err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_wr, issue_rd,
        input  wb0_valid, wb0_adr, wb0_data,
        input  wb1_valid, wb1_adr, wb1_data,
        output issue_stall, wb0_ready, wb1_ready,
        output reg_write, write_adr, write_data, busy, err
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file write scheduler: busy scoreboard with RAW/WAW issue stall and a 2:1 round-robin writeback arbiter.
// Latency: grant to register-file write is 1 cycle; backpressure via combinational issue_stall and wb ready.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    regfile_wb_scheduler_if.slave bus
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            rr_q;          // 0: wb0 wins a tie, 1: wb1 wins a tie
    logic            reg_write_q;
    logic [AW-1:0]   write_adr_q;
    logic [XLEN-1:0] write_data_q;
    logic            err_q;

    logic            issue_accept;
    logic            gnt0;
    logic            gnt1;
    logic            gnt_any;
    logic [AW-1:0]   gnt_adr;
    logic [XLEN-1:0] gnt_data;
    logic            gnt_nonzero;

    assign bus.issue_stall = bus.issue_valid &
                             (busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] |
                              (bus.issue_wr & busy_q[bus.issue_rd]));
    assign issue_accept    = bus.issue_valid & ~bus.issue_stall;

    assign gnt0        = bus.wb0_valid & (~bus.wb1_valid | ~rr_q);
    assign gnt1        = bus.wb1_valid & (~bus.wb0_valid |  rr_q);
    assign gnt_any     = gnt0 | gnt1;
    assign gnt_adr     = gnt1 ? bus.wb1_adr  : bus.wb0_adr;
    assign gnt_data    = gnt1 ? bus.wb1_data : bus.wb0_data;
    assign gnt_nonzero = gnt_any & (gnt_adr != '0);

    assign bus.wb0_ready  = gnt0;
    assign bus.wb1_ready  = gnt1;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_adr  = write_adr_q;
    assign bus.write_data = write_data_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;

    // Clear on the edge the register file captures the data; a new set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[write_adr_q] = 1'b0;
        end
        if (issue_accept && bus.issue_wr && (bus.issue_rd != '0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q       <= '0;
            rr_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            write_adr_q  <= '0;
            write_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            reg_write_q <= gnt_nonzero;
            if (gnt_any) begin
                write_adr_q  <= gnt_adr;
                write_data_q <= gnt_data;
            end
            if (bus.wb0_valid && bus.wb1_valid) begin
                rr_q <= ~rr_q;
            end
            if (gnt_nonzero && !busy_q[gnt_adr]) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: write-port scoreboard plus cycle-exact stall/grant/flag checks.
module tb_regfile_wb_scheduler;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    regfile_wb_scheduler_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) bus ();

    regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [AW-1:0]   adr;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the next expected write.
    always @(negedge i_clk) begin
        if (i_rst_n && bus.reg_write) begin
            wr_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got adr %0d data %h expected no write",
                         bus.write_adr, bus.write_data);
            end else begin
                e = exp_q.pop_front();
                check("write_adr", 64'(bus.write_adr), 64'(e.adr));
                check("write_data", 64'(bus.write_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic neg();
        @(negedge i_clk);
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rs1   = '0;
        bus.issue_rs2   = '0;
        bus.issue_wr    = 1'b0;
        bus.issue_rd    = '0;
        bus.wb0_valid   = 1'b0;
        bus.wb1_valid   = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic wr, input logic [AW-1:0] rd);
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
        bus.issue_wr    = wr;
        bus.issue_rd    = rd;
    endtask

    task automatic wb0(input logic v, input logic [AW-1:0] adr, input logic [XLEN-1:0] data);
        bus.wb0_valid = v;
        bus.wb0_adr   = adr;
        bus.wb0_data  = data;
    endtask

    task automatic wb1(input logic v, input logic [AW-1:0] adr, input logic [XLEN-1:0] data);
        bus.wb1_valid = v;
        bus.wb1_adr   = adr;
        bus.wb1_data  = data;
    endtask

    function automatic wr_t mk(input logic [AW-1:0] adr, input logic [XLEN-1:0] data);
        wr_t w;
        w.adr  = adr;
        w.data = data;
        return w;
    endfunction

    initial begin
        idle();
        wb0(1'b0, '0, '0);
        wb1(1'b0, '0, '0);
        repeat (2) tick();
        neg();
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_regwrite", 64'(bus.reg_write), 64'h0);
        check("rst_write_adr", 64'(bus.write_adr), 64'h0);
        check("rst_write_data", 64'(bus.write_data), 64'h0);
        check("rst_err", 64'(bus.err), 64'h0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // RAW on x5
        issue(0, 0, 1'b1, 5);
        neg(); check("raw_c0_stall", 64'(bus.issue_stall), 64'h0);
        tick();
        issue(5, 0, 1'b0, 0);
        neg(); check("raw_c1_stall", 64'(bus.issue_stall), 64'h1);
        check("raw_c1_busy", 64'(bus.busy), 64'h20);
        tick();
        neg(); check("raw_c2_stall", 64'(bus.issue_stall), 64'h1);
        tick();
        wb0(1'b1, 5, 32'hDEAD_BEEF);
        exp_q.push_back(mk(5, 32'hDEAD_BEEF));
        neg(); check("raw_c3_ready0", 64'(bus.wb0_ready), 64'h1);
        check("raw_c3_stall", 64'(bus.issue_stall), 64'h1);
        tick();
        bus.wb0_valid = 1'b0;
        neg(); check("raw_c4_regwrite", 64'(bus.reg_write), 64'h1);
        check("raw_c4_stall", 64'(bus.issue_stall), 64'h1);
        tick();
        neg(); check("raw_c5_stall", 64'(bus.issue_stall), 64'h0);
        check("raw_c5_busy", 64'(bus.busy), 64'h0);
        tick();
        idle();

        // Round-robin: first tie goes to wb0, next tie to wb1
        issue(0, 0, 1'b1, 3); tick();
        issue(0, 0, 1'b1, 4); tick();
        idle();
        wb0(1'b1, 3, 32'hAAAA_0003);
        wb1(1'b1, 4, 32'hBBBB_0004);
        exp_q.push_back(mk(3, 32'hAAAA_0003));
        neg(); check("rr1_ready0", 64'(bus.wb0_ready), 64'h1);
        check("rr1_ready1", 64'(bus.wb1_ready), 64'h0);
        check("rr1_busy", 64'(bus.busy), 64'h18);
        tick();
        bus.wb0_valid = 1'b0;
        exp_q.push_back(mk(4, 32'hBBBB_0004));
        neg(); check("rr1b_ready1", 64'(bus.wb1_ready), 64'h1);
        check("rr1b_ready0", 64'(bus.wb0_ready), 64'h0);
        tick();
        bus.wb1_valid = 1'b0;
        tick(); tick();
        neg(); check("rr1_busy_clear", 64'(bus.busy), 64'h0);
        tick();
        issue(0, 0, 1'b1, 10); tick();
        issue(0, 0, 1'b1, 11); tick();
        idle();
        wb0(1'b1, 10, 32'hCCCC_000A);
        wb1(1'b1, 11, 32'hDDDD_000B);
        exp_q.push_back(mk(11, 32'hDDDD_000B));
        neg(); check("rr2_ready1", 64'(bus.wb1_ready), 64'h1);
        check("rr2_ready0", 64'(bus.wb0_ready), 64'h0);
        tick();
        bus.wb1_valid = 1'b0;
        exp_q.push_back(mk(10, 32'hCCCC_000A));
        neg(); check("rr2b_ready0", 64'(bus.wb0_ready), 64'h1);
        tick();
        bus.wb0_valid = 1'b0;
        tick(); tick();
        neg(); check("rr2_busy_clear", 64'(bus.busy), 64'h0);
        tick();

        // x0 never becomes busy and is never written
        issue(0, 0, 1'b1, 0);
        neg(); check("x0_stall", 64'(bus.issue_stall), 64'h0);
        tick();
        idle();
        neg(); check("x0_busy", 64'(bus.busy), 64'h0);
        tick();
        wb1(1'b1, 0, 32'h0000_1234);
        neg(); check("x0_ready1", 64'(bus.wb1_ready), 64'h1);
        tick();
        bus.wb1_valid = 1'b0;
        neg(); check("x0_regwrite", 64'(bus.reg_write), 64'h0);
        check("x0_err", 64'(bus.err), 64'h0);
        tick();

        // WAW on x7
        issue(0, 0, 1'b1, 7); tick();
        neg(); check("waw_stall_a", 64'(bus.issue_stall), 64'h1);
        tick();
        wb0(1'b1, 7, 32'h0000_0077);
        exp_q.push_back(mk(7, 32'h0000_0077));
        neg(); check("waw_stall_b", 64'(bus.issue_stall), 64'h1);
        check("waw_ready0", 64'(bus.wb0_ready), 64'h1);
        tick();
        bus.wb0_valid = 1'b0;
        neg(); check("waw_stall_wr", 64'(bus.issue_stall), 64'h1);
        tick();
        neg(); check("waw_stall_free", 64'(bus.issue_stall), 64'h0);
        tick();
        idle();
        neg(); check("waw_busy_reset", 64'(bus.busy), 64'h80);
        tick();
        wb0(1'b1, 7, 32'h0000_0078);
        exp_q.push_back(mk(7, 32'h0000_0078));
        tick();
        bus.wb0_valid = 1'b0;
        tick();
        neg(); check("waw_busy_clear", 64'(bus.busy), 64'h0);
        tick();

        // Writeback to a non-busy register raises the sticky error but still writes
        wb0(1'b1, 9, 32'h0000_0099);
        exp_q.push_back(mk(9, 32'h0000_0099));
        neg(); check("err_ready0", 64'(bus.wb0_ready), 64'h1);
        check("err_before", 64'(bus.err), 64'h0);
        tick();
        bus.wb0_valid = 1'b0;
        neg(); check("err_set", 64'(bus.err), 64'h1);
        tick(); tick(); tick();
        neg(); check("err_sticky", 64'(bus.err), 64'h1);
        tick();

        // Asynchronous reset with a write in flight and busy = 0x6
        issue(0, 0, 1'b1, 1); tick();
        issue(0, 0, 1'b1, 2); tick();
        idle();
        neg(); check("mid_busy", 64'(bus.busy), 64'h6);
        tick();
        wb0(1'b1, 1, 32'h1111_1111);
        exp_q.push_back(mk(1, 32'h1111_1111));
        tick();
        wb0(1'b1, 2, 32'h2222_2222);
        check("mid_regwrite_pre", 64'(bus.reg_write), 64'h1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'h0);
        check("arst_regwrite", 64'(bus.reg_write), 64'h0);
        check("arst_err", 64'(bus.err), 64'h0);
        // the write to x1 was presented before reset; drop its scoreboard entry
        void'(exp_q.pop_front());
        tick(); tick();
        idle();
        i_rst_n = 1'b1;
        neg(); check("rel_regwrite", 64'(bus.reg_write), 64'h0);
        tick();
        neg(); check("rel_regwrite_edge1", 64'(bus.reg_write), 64'h0);
        check("rel_busy", 64'(bus.busy), 64'h0);
        tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
